alarm_multi_ctrl: RTL
=====================

# alarm_multi_ctrl

Parametrised multi-channel alarm controller for the digital clock. Watches the current second-of-day counter, triggers each enabled channel when its target second is reached, and keeps it ringing for that channel's programmed length. Supports dismiss and snooze with a snooze limit, and is immune to midnight wrap-around. It sits between the timekeeping counter and the buzzer/LED driver, replacing the single-channel alarm-length logic.

## Interface
- `N_ALM`, default 4: number of alarm channels (1..8).
- `SEC_W`, default 17: width of second-of-day values.
- `SNOOZE_SEC`, default 300: snooze interval in seconds.
- `MAX_SNOOZE`, default 3: snoozes allowed per trigger.
- `sec_clk` in 1: 1 Hz clock. All state advances on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cur_sec` in SEC_W: current second of day, 0..86399.
- `enable` in N_ALM: per-channel arm bit.
- `tar_sec` in N_ALM*SEC_W: channel i target is `tar_sec[i*SEC_W +: SEC_W]`.
- `len_s` in 2*N_ALM: channel i ring-length code is `len_s[2i +: 2]`. The codes are 0 = 15 s, 1 = 30 s, 2 = 45 s, 3 = 60 s.
- `off` in 1: dismiss all ringing channels.
- `snooze` in 1: snooze all ringing channels.
- `ring_vec` out N_ALM: per-channel ringing flag (registered).
- `alarming` out 1: OR of `ring_vec` (registered).
- `active_idx` out clog2(N_ALM) (min 1): lowest-index ringing channel, or 0 if none (registered).

## Operation
- Each channel runs its own FSM with states IDLE, RINGING, SNOOZED and DONE. Each channel also has:
  - a 6-bit ring counter `rem`;
  - a snooze counter sized clog2(SNOOZE_SEC+1);
  - a snooze tally sized clog2(MAX_SNOOZE+1).
- IDLE → RINGING when `enable[i]` is set and the sampled `cur_sec == tar_sec_i`.
  - `rem` loads length−1 (14/29/44/59).
  - The tally clears.
- RINGING behaviour, in priority order:
  - `off` → DONE.
  - `snooze` with tally < MAX_SNOOZE → SNOOZED. The snooze counter loads SNOOZE_SEC−1 and the tally increments.
  - `snooze` with tally == MAX_SNOOZE → DONE (treated as off).
  - `rem == 0` → DONE.
  - Otherwise `rem` decrements.
- SNOOZED:
  - Counter 0 → RINGING, with `rem` reloaded from the current `len_s`.
  - Otherwise the counter decrements.
  - `off` → DONE.
  - `snooze` is ignored.
- DONE → IDLE when `cur_sec != tar_sec_i`. Freezing the time while it is being set therefore cannot re-trigger the channel.
- `enable[i]` low forces IDLE from any state on the next edge.
- `off` and `snooze` asserted together: `off` wins.
- `off` and `snooze` act only on channels that are RINGING or SNOOZED (per the rules above). Channels in IDLE or DONE ignore them.
- Length is counted in ticks, not compared against `cur_sec`, so a window spanning 86399→0 behaves identically to any other window.
- A target skipped by a `cur_sec` jump does not trigger. A `cur_sec` value ≥ 86400 never matches.
- A target change while RINGING does not affect the current ring.
- `len_s` is sampled only on load and reload.

## Timing
- Reset values:
  - `ring_vec` = 0, `alarming` = 0, `active_idx` = 0.
  - All FSMs in IDLE, all counters 0.
- Trigger latency: on the edge that samples `cur_sec == tar_sec_i`, `ring_vec[i]` rises and stays high for exactly L edges (L = 15/30/45/60).
- `off` and `snooze` take effect on the edge that samples them. `ring_vec` falls right after that edge.
- After a snooze, ringing resumes exactly SNOOZE_SEC edges after the edge that sampled `snooze`.
- Reset asserted mid-ring clears everything on that edge. After reset, the same target second re-triggers only if `cur_sec` matches again.
- Outputs are updated only on `sec_clk` edges. There is no combinational input-to-output path.

## Configuration
- `ALARM_SNOOZE_EN` defined: snooze behaves as specified above.
- `ALARM_SNOOZE_EN` undefined:
  - SNOOZED state, snooze counter and tally are not built.
  - The `snooze` port remains and is ignored.
  - RINGING leaves only on `off`, on `rem == 0`, or on enable low.

## Test plan
- Ring length: N_ALM=4, ch0 `tar`=100, `len_s`=1, enabled; step `cur_sec` 99→140 → `ring_vec[0]` high for samples 100..129 (30 edges), then low. DONE→IDLE when `cur_sec` ≠ 100.
- Midnight wrap: ch1 `tar`=86390, `len_s`=0, `cur_sec` wraps to 0 → `alarming` high for 15 edges across the wrap.
- Dismiss and simultaneous triggers: ch0 and ch2 both `tar`=500 → `ring_vec`=0101, `active_idx`=0. `off` on the 3rd edge → both fall. `off`+`snooze` together → treated as off.
- Snooze (with `ALARM_SNOOZE_EN`, SNOOZE_SEC=5, MAX_SNOOZE=2):
  - `snooze` at ring edge 2 → low 5 edges, then rings again for a full length.
  - 2nd snooze behaves the same.
  - 3rd snooze → DONE.
- Without `ALARM_SNOOZE_EN`: `snooze` has no effect and the ring lasts the full length.
- Enable, reset and frozen time:
  - Drop `enable[0]` mid-ring → falls on the next edge.
  - `rst` mid-ring → all outputs 0 on that edge.
  - Hold `cur_sec`=`tar` for 3 edges after `off` → no re-trigger.

Source files
------------

// File: rtl/alarm_multi_ctrl.sv
// Multi-channel 1 Hz alarm: per-channel trigger on target second, tick-counted ring length, dismiss.
// Snooze (SNOOZED state, counter, tally) is built only when ALARM_SNOOZE_EN is defined.
module alarm_multi_ctrl #(
    parameter int N_ALM      = 4,
    parameter int SEC_W      = 17,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    localparam int IDX_W     = (N_ALM > 1) ? $clog2(N_ALM) : 1
) (
    input  logic                   sec_clk,
    input  logic                   rst,
    input  logic [SEC_W-1:0]       cur_sec,
    input  logic [N_ALM-1:0]       enable,
    input  logic [N_ALM*SEC_W-1:0] tar_sec,
    input  logic [2*N_ALM-1:0]     len_s,
    input  logic                   off,
    input  logic                   snooze,
    output logic [N_ALM-1:0]       ring_vec,
    output logic                   alarming,
    output logic [IDX_W-1:0]       active_idx
);

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
    localparam int TAL_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [TAL_W-1:0] TAL_MAX  = TAL_W'(MAX_SNOOZE);
`else
    wire unused_snooze = snooze ^ (SNOOZE_SEC != 0) ^ (MAX_SNOOZE != 0);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RING = 2'd1,
`ifdef ALARM_SNOOZE_EN
        S_SNZ  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    function automatic logic [5:0] ring_len_m1(input logic [1:0] code);
        case (code)
            2'd0:    return 6'd14;
            2'd1:    return 6'd29;
            2'd2:    return 6'd44;
            default: return 6'd59;
        endcase
    endfunction

    // Values past the last second of the day must never match a target.
    logic in_day;
    assign in_day = (32'(cur_sec) < 32'd86400);

    logic [N_ALM-1:0] ring_nx;
    logic [IDX_W-1:0] idx_nx;

    for (genvar gi = 0; gi < N_ALM; gi++) begin : g_ch
        state_t           st, st_nx;
        logic [5:0]       rem, rem_nx;
        logic [SEC_W-1:0] tar;
        logic [1:0]       len_c;
        logic             at_tar;
`ifdef ALARM_SNOOZE_EN
        logic [SNZ_W-1:0] scnt, scnt_nx;
        logic [TAL_W-1:0] tally, tally_nx;
`endif

        assign tar    = tar_sec[gi*SEC_W +: SEC_W];
        assign len_c  = len_s[2*gi +: 2];
        assign at_tar = in_day && (cur_sec == tar);

        always_comb begin
            st_nx  = st;
            rem_nx = rem;
`ifdef ALARM_SNOOZE_EN
            scnt_nx  = scnt;
            tally_nx = tally;
`endif
            if (!enable[gi]) begin
                st_nx = S_IDLE;
            end else begin
                case (st)
                    S_IDLE: if (at_tar) begin
                        st_nx  = S_RING;
                        rem_nx = ring_len_m1(len_c);
`ifdef ALARM_SNOOZE_EN
                        tally_nx = '0;
`endif
                    end
                    S_RING: if (off) begin
                        st_nx = S_DONE;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze && (tally < TAL_MAX)) begin
                        st_nx    = S_SNZ;
                        scnt_nx  = SNZ_LOAD;
                        tally_nx = tally + 1'b1;
                    end else if (snooze) begin
                        st_nx = S_DONE;
`endif
                    end else if (rem == 6'd0) begin
                        st_nx = S_DONE;
                    end else begin
                        rem_nx = rem - 6'd1;
                    end
`ifdef ALARM_SNOOZE_EN
                    S_SNZ: if (off) begin
                        st_nx = S_DONE;
                    end else if (scnt == '0) begin
                        st_nx  = S_RING;
                        rem_nx = ring_len_m1(len_c);
                    end else begin
                        scnt_nx = scnt - 1'b1;
                    end
`endif
                    // Raw compare: a frozen clock parked on the target keeps the channel here.
                    S_DONE: if (cur_sec != tar) st_nx = S_IDLE;
                    default: st_nx = S_IDLE;
                endcase
            end
        end

        always_ff @(posedge sec_clk) begin
            if (rst) begin
                st  <= S_IDLE;
                rem <= '0;
`ifdef ALARM_SNOOZE_EN
                scnt  <= '0;
                tally <= '0;
`endif
            end else begin
                st  <= st_nx;
                rem <= rem_nx;
`ifdef ALARM_SNOOZE_EN
                scnt  <= scnt_nx;
                tally <= tally_nx;
`endif
            end
        end

        assign ring_nx[gi] = (st_nx == S_RING);
    end

    always_comb begin
        idx_nx = '0;
        for (int i = N_ALM - 1; i >= 0; i--) begin
            if (ring_nx[i]) idx_nx = IDX_W'(i);
        end
    end

    // Outputs are registered from next-state so they change on the sampling edge itself.
    always_ff @(posedge sec_clk) begin
        if (rst) begin
            ring_vec   <= '0;
            alarming   <= 1'b0;
            active_idx <= '0;
        end else begin
            ring_vec   <= ring_nx;
            alarming   <= |ring_nx;
            active_idx <= idx_nx;
        end
    end

endmodule
